// File: rtl/simple_adder_decoder_if.sv
// Handshake and data bundle between an adder-result source and the decoder.
// master drives the sum/OR pair and out_ready; slave is the decoder side.
interface simple_adder_decoder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   sum_in;
  logic [WIDTH-1:0] or_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] and_out;
  logic [WIDTH-1:0] xor_out;
  logic             err;

  modport master (
    output in_valid, sum_in, or_in, out_ready,
    input  in_ready, out_valid, and_out, xor_out, err
  );

  modport slave (
    input  in_valid, sum_in, or_in, out_ready,
    output in_ready, out_valid, and_out, xor_out, err
  );
endinterface

// File: rtl/simple_adder_decoder.sv
// Recovers in1&in2 and in1^in2 from a registered sum/OR pair with a bit-serial
// subtractor (and = sum - or), flagging pairs no operand pair could produce.
module simple_adder_decoder #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  simple_adder_decoder_if.slave bus,
  output logic [1:0]            o_dbg_state
);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops without a transfer, data is stable while valid.
  localparam int IDXW = $clog2(WIDTH + 2);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH:0]   r_sum;
  logic [WIDTH-1:0] r_or;
  logic [WIDTH:0]   r_diff;
  logic             r_borrow;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_and;
  logic [WIDTH-1:0] r_xor;
  logic             r_err;

  logic [WIDTH:0]   w_or_ext;
  logic             w_s;
  logic             w_o;
  logic             w_bit;
  logic             w_borrow_next;
  logic [WIDTH:0]   w_diff_upd;
  logic             w_err;

  always_comb begin
    w_or_ext      = {1'b0, r_or};
    w_s           = r_sum[r_idx];
    w_o           = w_or_ext[r_idx];
    w_bit         = w_s ^ w_o ^ r_borrow;
    w_borrow_next = (~w_s & (w_o | r_borrow)) | (w_o & r_borrow);
    w_diff_upd        = r_diff;
    w_diff_upd[r_idx] = w_bit;
    // Underflow, a set top bit, or AND bits outside the OR word are impossible.
    w_err = w_borrow_next | w_diff_upd[WIDTH] |
            (|(w_diff_upd[WIDTH-1:0] & ~r_or));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sum    <= '0;
      r_or     <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_and    <= '0;
      r_xor    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sum    <= bus.sum_in;
            r_or     <= bus.or_in;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_diff   <= w_diff_upd;
          r_borrow <= w_borrow_next;
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_err   <= w_err;
            r_and   <= w_err ? '0 : w_diff_upd[WIDTH-1:0];
            r_xor   <= w_err ? '0 : (r_or & ~w_diff_upd[WIDTH-1:0]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.and_out   = r_and;
  assign bus.xor_out   = r_xor;
  assign bus.err       = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_simple_adder_decoder.sv
// Directed and random checks of simple_adder_decoder against an arithmetic
// reference (and = sum - or, with impossible pairs flagged).
module tb_simple_adder_decoder;
  localparam int W = 8;
  localparam int LAT = W + 1;
  localparam int PERIOD = W + 3;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  simple_adder_decoder_if #(.WIDTH(W)) bus ();

  simple_adder_decoder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int acc_cyc  = 0;

  logic [2*W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  // reference: {err, and, xor} straight from the sum/OR arithmetic
  function automatic logic [2*W:0] model(input logic [W:0] s, input logic [W-1:0] o);
    int d;
    logic e;
    logic [W-1:0] a;
    d = int'(s) - int'(o);
    e = (d < 0) || (d > (2**W - 1)) || (((d & ~int'(o)) & (2**W - 1)) != 0);
    a = e ? '0 : W'(d);
    return {e, a, (e ? W'(0) : (o & ~a))};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: start and end on a falling edge
  task automatic send(input logic [W:0] s, input logic [W-1:0] o);
    bus.sum_in   = s;
    bus.or_in    = o;
    bus.in_valid = 1'b1;
    check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic [2*W:0] e);
    check({tag, "_err"}, 32'(bus.err), 32'(e[2*W]));
    check({tag, "_and"}, 32'(bus.and_out), 32'(e[2*W-1:W]));
    check({tag, "_xor"}, 32'(bus.xor_out), 32'(e[W-1:0]));
  endtask

  initial begin
    int lat;
    int c0;
    int seen;
    int prev_acc;
    logic [W-1:0]   in1, in2;
    logic [2*W:0]   e;
    logic [2*W-1:0] pair;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum_in    = '0;
    bus.or_in     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_and", 32'(bus.and_out), 32'd0);
    check("rst_xor", 32'(bus.xor_out), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // operands 0x5A, 0x3C
    send(9'h096, 8'h7E);
    wait_out(lat);
    check("t1_latency", 32'(lat), 32'(LAT));
    check_result("t1", model(9'h096, 8'h7E));
    check("t1_and_const", 32'(bus.and_out), 32'h18);
    check("t1_xor_const", 32'(bus.xor_out), 32'h66);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t1_handoff_valid", 32'(bus.out_valid), 32'd0);
    check("t1_handoff_ready", 32'(bus.in_ready), 32'd1);

    // asynchronous reset in the 4th CALC cycle; previous result is still held
    send(9'h1FE, 8'hFF);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_and", 32'(bus.and_out), 32'd0);
    check("async_rst_xor", 32'(bus.xor_out), 32'd0);
    check("async_rst_err", 32'(bus.err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("dropped_pair_no_valid", 32'(seen), 32'd0);
    send(9'h000, 8'h00);
    wait_out(lat);
    check("zero_latency", 32'(lat), 32'(LAT));
    check_result("zero", model(9'h000, 8'h00));
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // backpressure: A = 0xFF+0xFF held, B = underflow pair waiting on in_valid
    bus.sum_in   = 9'h1FE;
    bus.or_in    = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.sum_in = 9'h010;
    bus.or_in  = 8'h20;
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    check("bp_and_const", 32'(bus.and_out), 32'hFF);
    check("bp_xor_const", 32'(bus.xor_out), 32'h00);
    e  = model(9'h1FE, 8'hFF);
    c0 = acc_cnt;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      check_result("bp_hold", e);
    end
    check("bp_no_second_accept", 32'(acc_cnt), 32'(c0));
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_handoff_valid", 32'(bus.out_valid), 32'd0);
    check("bp_handoff_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_next_accept_cnt", 32'(acc_cnt), 32'(c0 + 1));
    check("bp_next_accept_state", 32'(dbg_state), 32'd1);
    wait_out(lat);
    check("underflow_latency", 32'(lat), 32'(LAT));
    check_result("underflow", model(9'h010, 8'h20));
    check("underflow_err_const", 32'(bus.err), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // AND bits not a subset of OR; out_ready already high before out_valid
    send(9'h030, 8'h20);
    wait_out(lat);
    check("subset_latency", 32'(lat), 32'(LAT));
    check_result("subset", model(9'h030, 8'h20));
    check("subset_err_const", 32'(bus.err), 32'd1);
    @(posedge clk);
    @(negedge clk);

    // back-to-back random legal pairs with out_ready tied high
    prev_acc = 0;
    for (int i = 0; i < 20; i++) begin
      in1 = W'($urandom_range(0, 2**W - 1));
      in2 = W'($urandom_range(0, 2**W - 1));
      bus.sum_in   = {1'b0, in1} + {1'b0, in2};
      bus.or_in    = in1 | in2;
      bus.in_valid = 1'b1;
      exp_q.push_back({in1 & in2, in1 ^ in2});
      c0 = acc_cnt;
      lat = 0;
      while (acc_cnt == c0 && lat < 40) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      check("b2b_accepted", 32'(acc_cnt), 32'(c0 + 1));
      if (i > 0) check("b2b_spacing", 32'(acc_cyc - prev_acc), 32'(PERIOD));
      prev_acc = acc_cyc;
      wait_out(lat);
      check("b2b_latency", 32'(lat), 32'(LAT));
      pair = exp_q.pop_front();
      check("b2b_err", 32'(bus.err), 32'd0);
      check("b2b_and", 32'(bus.and_out), 32'(pair[2*W-1:W]));
      check("b2b_xor", 32'(bus.xor_out), 32'(pair[W-1:0]));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("final_idle", 32'(bus.in_ready), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
